// File: rtl/systolic_drain_deskew.sv
// rtl/systolic_drain_deskew.sv - deskews the systolic array bottom-row output into aligned rows
// and streams them through a first-word fall-through FIFO tagged with row index / tile-last.
module systolic_drain_deskew #(
  parameter int cols       = 16,
  parameter int op_width   = 32,
  parameter int fifo_depth = 32,
  parameter int cnt_width  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [cnt_width-1:0]             tile_len,
  input  logic                             in_valid,
  input  logic [cols*op_width-1:0]         in_row,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [cols*op_width-1:0]         out_data,
  output logic [cnt_width-1:0]             out_index,
  output logic                             out_last,
  output logic                             tile_done,
  output logic                             overflow,
  output logic [$clog2(fifo_depth+1)-1:0]  fifo_count
);

  localparam int rw = cols * op_width;
  localparam int aw = $clog2(fifo_depth);
  localparam int cw = $clog2(fifo_depth + 1);
  localparam int ew = cnt_width + rw;

  logic [rw-1:0]        aligned;
  logic [cols-2:0]      vpipe;
  logic                 wr_valid;
  logic [ew-1:0]        mem [fifo_depth];
  logic [aw-1:0]        rd_ptr, wr_ptr;
  logic [cw-1:0]        count;
  logic [cnt_width-1:0] wr_index, tile_len_q;
  logic                 overflow_q, tile_done_q;
  logic                 full, pop, do_push, drop;
  logic [ew-1:0]        head;

  // Column j is delayed (cols-1-j) cycles so every column of a token lines up with the last one.
  for (genvar j = 0; j < cols; j++) begin : g_col
    if (j == cols - 1) begin : g_direct
      assign aligned[j*op_width +: op_width] = in_row[j*op_width +: op_width];
    end else begin : g_pipe
      logic [op_width-1:0] pipe [cols-1-j];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < cols - 1 - j; s++) pipe[s] <= '0;
        end else begin
          pipe[0] <= in_row[j*op_width +: op_width];
          for (int s = 1; s < cols - 1 - j; s++) pipe[s] <= pipe[s-1];
        end
      end
      assign aligned[j*op_width +: op_width] = pipe[cols-2-j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= in_valid;
      for (int s = 1; s < cols - 1; s++) vpipe[s] <= vpipe[s-1];
    end
  end

  assign wr_valid = vpipe[cols-2];
  assign full     = (count == cw'(fifo_depth));
  assign pop      = out_valid && out_ready;
  assign do_push  = wr_valid && (!full || pop);
  assign drop     = wr_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst && !start && do_push) mem[wr_ptr] <= {wr_index, aligned};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wr_index    <= '0;
      tile_len_q  <= '0;
      overflow_q  <= 1'b0;
      tile_done_q <= 1'b0;
    end else if (start) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wr_index    <= '0;
      tile_len_q  <= tile_len;
      overflow_q  <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Dropped rows still consume an index so the gap is visible downstream.
      if (wr_valid) wr_index <= wr_index + 1'b1;
      if (drop) overflow_q <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      tile_done_q <= pop && out_last;
    end
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? head[rw-1:0] : '0;
  assign out_index  = out_valid ? head[rw +: cnt_width] : '0;
  assign out_last   = out_valid && (tile_len_q != '0) && (out_index == tile_len_q - cnt_width'(1));
  assign tile_done  = tile_done_q;
  assign overflow   = overflow_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_systolic_drain_deskew.sv
// tb/tb_systolic_drain_deskew.sv - directed bench: a deep-FIFO instance (a) and a 4-entry instance (b)
// share the same stimulus.
module tb_systolic_drain_deskew;

  localparam int RW = 128;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [15:0]   tile_len;
  logic [RW-1:0] in_row;

  logic          v_a, last_a, done_a, ovf_a;
  logic [RW-1:0] d_a;
  logic [15:0]   i_a;
  logic [5:0]    cnt_a;
  logic          v_b, last_b, done_b, ovf_b;
  logic [RW-1:0] d_b;
  logic [15:0]   i_b;
  logic [2:0]    cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_drain_deskew #(.cols(4), .op_width(32), .fifo_depth(32), .cnt_width(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .tile_len(tile_len), .in_valid(in_valid), .in_row(in_row),
    .out_valid(v_a), .out_ready(out_ready), .out_data(d_a), .out_index(i_a), .out_last(last_a),
    .tile_done(done_a), .overflow(ovf_a), .fifo_count(cnt_a));

  systolic_drain_deskew #(.cols(4), .op_width(32), .fifo_depth(4), .cnt_width(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .tile_len(tile_len), .in_valid(in_valid), .in_row(in_row),
    .out_valid(v_b), .out_ready(out_ready), .out_data(d_b), .out_index(i_b), .out_last(last_b),
    .tile_done(done_b), .overflow(ovf_b), .fifo_count(cnt_b));

  typedef struct {
    logic          st;
    logic [15:0]   tl;
    logic          iv;
    logic [RW-1:0] row;
    logic          rdy;
    logic          ev;
    logic [RW-1:0] ed;
    logic [15:0]   ei;
    logic          el;
    logic          etd;
    logic          eov;
    logic [5:0]    ecnt;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [RW-1:0] mkrow(input int k);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'(100 * k + j);
    return r;
  endfunction

  // Column j of token k is on the bus in cycle k+j.
  function automatic logic [RW-1:0] skew_row(input int c, input int ntok, input int base);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      if (c - j >= 0 && c - j < ntok) r[j*32 +: 32] = 32'(100 * (base + c - j) + j);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [15:0] tl, input logic iv,
                       input logic [RW-1:0] row, input logic rdy);
    start = st; tile_len = tl; in_valid = iv; in_row = row; out_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] tl, input logic rdy);
    drive(1'b1, tl, 1'b0, '0, rdy);
    next_cycle();
  endtask

  int exp_i;

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'd0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_a", RW'(v_a), RW'(0));
    chk("rst_data_a", d_a, '0);
    chk("rst_index_a", RW'(i_a), RW'(0));
    chk("rst_last_a", RW'(last_a), RW'(0));
    chk("rst_done_a", RW'(done_a), RW'(0));
    chk("rst_ovf_a", RW'(ovf_a), RW'(0));
    chk("rst_cnt_a", RW'(cnt_a), RW'(0));
    chk("rst_valid_b", RW'(v_b), RW'(0));
    chk("rst_last_b", RW'(last_b), RW'(0));
    chk("rst_done_b", RW'(done_b), RW'(0));
    next_cycle();

    // Basic tile: tile_len=3, three back-to-back tokens, out_ready always 1.
    for (int v = 0; v < 10; v++) begin
      int c;
      c = v - 1;
      vecs[v].st = (v == 0); vecs[v].tl = 16'd3; vecs[v].rdy = 1'b1;
      vecs[v].iv = (c >= 0 && c <= 2);
      vecs[v].row = (c >= 0) ? skew_row(c, 3, 0) : '0;
      vecs[v].ev = 1'b0; vecs[v].ed = '0; vecs[v].ei = '0; vecs[v].el = 1'b0;
      vecs[v].etd = 1'b0; vecs[v].eov = 1'b0; vecs[v].ecnt = '0;
      if (c >= 4 && c <= 6) begin
        vecs[v].ev = 1'b1; vecs[v].ed = mkrow(c - 4); vecs[v].ei = 16'(c - 4); vecs[v].ecnt = 6'd1;
      end
      vecs[v].el  = (c == 6);
      vecs[v].etd = (c == 7);
    end
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].st, vecs[v].tl, vecs[v].iv, vecs[v].row, vecs[v].rdy);
      @(negedge clk);
      chk($sformatf("t1_valid[%0d]", v), RW'(v_a), RW'(vecs[v].ev));
      chk($sformatf("t1_data[%0d]", v), d_a, vecs[v].ed);
      chk($sformatf("t1_index[%0d]", v), RW'(i_a), RW'(vecs[v].ei));
      chk($sformatf("t1_last[%0d]", v), RW'(last_a), RW'(vecs[v].el));
      chk($sformatf("t1_done[%0d]", v), RW'(done_a), RW'(vecs[v].etd));
      chk($sformatf("t1_ovf[%0d]", v), RW'(ovf_a), RW'(vecs[v].eov));
      chk($sformatf("t1_cnt[%0d]", v), RW'(cnt_a), RW'(vecs[v].ecnt));
      next_cycle();
    end

    // Overflow on the 4-deep FIFO: six tokens with no drain.
    do_start(16'd0, 1'b0);
    for (int c = 0; c < 11; c++) begin
      drive(1'b0, 16'd0, c < 6, skew_row(c, 6, 0), 1'b0);
      @(negedge clk);
      if (c == 7) begin
        chk("t2_cnt_c7", RW'(cnt_b), RW'(4));
        chk("t2_ovf_c7", RW'(ovf_b), RW'(0));
      end
      if (c == 8) begin
        chk("t2_cnt_c8", RW'(cnt_b), RW'(4));
        chk("t2_ovf_c8", RW'(ovf_b), RW'(1));
      end
      next_cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 16'd0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("t2_valid[%0d]", i), RW'(v_b), RW'(1));
        chk($sformatf("t2_index[%0d]", i), RW'(i_b), RW'(i));
        chk($sformatf("t2_data[%0d]", i), d_b, mkrow(i));
      end else begin
        chk($sformatf("t2_empty[%0d]", i), RW'(v_b), RW'(0));
      end
      next_cycle();
    end
    chk("t2_ovf_sticky", RW'(ovf_b), RW'(1));

    // Full FIFO with a pop in the same cycle as the fifth aligned write.
    do_start(16'd0, 1'b0);
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 16'd0, c < 5, skew_row(c, 5, 0), c == 7);
      @(negedge clk);
      if (c == 7) chk("t3_cnt_full", RW'(cnt_b), RW'(4));
      if (c == 8) begin
        chk("t3_cnt_after", RW'(cnt_b), RW'(4));
        chk("t3_ovf", RW'(ovf_b), RW'(0));
      end
      next_cycle();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'd0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("t3_index[%0d]", i), RW'(i_b), RW'(i + 1));
        chk($sformatf("t3_data[%0d]", i), d_b, mkrow(i + 1));
      end else begin
        chk("t3_empty", RW'(v_b), RW'(0));
      end
      next_cycle();
    end

    // Backpressure: out_ready toggles every cycle over 8 back-to-back tokens.
    do_start(16'd0, 1'b0);
    exp_i = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 16'd0, c < 8, skew_row(c, 8, 0), c[0]);
      @(negedge clk);
      if (v_a) begin
        chk("t4_index", RW'(i_a), RW'(exp_i));
        chk("t4_data", d_a, mkrow(exp_i));
        if (out_ready) exp_i++;
      end
      next_cycle();
    end
    chk("t4_delivered", RW'(exp_i), RW'(8));
    chk("t4_ovf", RW'(ovf_a), RW'(0));

    // start in cycle 2 while the cycle-0 token is still in the skew pipeline.
    do_start(16'd0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      drive(c == 2, 16'd0, c == 0 || c == 5, skew_row(c, 1, 5) | skew_row(c - 5, 1, 7), 1'b1);
      @(negedge clk);
      if (c >= 3 && c <= 8) begin
        chk($sformatf("t5_novalid[%0d]", c), RW'(v_a), RW'(0));
        chk($sformatf("t5_ovf[%0d]", c), RW'(ovf_a), RW'(0));
      end
      if (c == 9) begin
        chk("t5_valid", RW'(v_a), RW'(1));
        chk("t5_index", RW'(i_a), RW'(0));
        chk("t5_data", d_a, mkrow(7));
      end
      next_cycle();
    end

    // tile_len=0: unbounded tile, no last marker, no tile_done.
    do_start(16'd0, 1'b1);
    exp_i = 0;
    for (int c = 0; c < 13; c++) begin
      drive(1'b0, 16'd0, c < 5, skew_row(c, 5, 0), 1'b1);
      @(negedge clk);
      chk("t6_done", RW'(done_a), RW'(0));
      if (v_a) begin
        chk("t6_index", RW'(i_a), RW'(exp_i));
        chk("t6_last", RW'(last_a), RW'(0));
        exp_i++;
      end
      next_cycle();
    end
    chk("t6_count", RW'(exp_i), RW'(5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
